// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder slice reused over N cycles with a carry flip-flop.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN.
module serial_adder #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         sub,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] S,
  output logic         C,
  output logic         s_bit,
  output logic         s_bit_vld
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(N - 1);

  state_e           state_q, state_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic             cy_q, cy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     s_q, s_d;
  logic             c_q, c_d;

  // Operand B and carry-in as loaded on an accepted start.
  logic [N-1:0] b_load;
  logic         cin_load;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_load   = sub ? ~B : B;
  assign cin_load = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_load     = B;
  assign cin_load   = 1'b0;
`endif

  // Full-adder slice built from two half-adder stages plus the carry OR.
  logic ha0_s, ha0_c, ha1_s, ha1_c, fa_c;

  always_comb begin
    ha0_s = a_q[0] ^ b_q[0];
    ha0_c = a_q[0] & b_q[0];
    ha1_s = ha0_s ^ cy_q;
    ha1_c = ha0_s & cy_q;
    fa_c  = ha0_c | ha1_c;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    c_d     = c_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = A;
          b_d     = b_load;
          cy_d    = cin_load;
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end

      StRun: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        cy_d  = fa_c;
        s_d   = {ha1_s, s_q[N-1:1]};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LastCnt) begin
          c_d     = fa_c;
          state_d = StDone;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      c_q     <= c_d;
    end
  end

  always_comb begin
    busy      = (state_q == StRun);
    done      = (state_q == StDone);
    s_bit_vld = busy;
    s_bit     = busy & ha1_s;
    S         = s_q;
    C         = c_q;
  end

endmodule
